// File: rtl/hack_screen_scanner_if.sv
// rtl/hack_screen_scanner_if.sv - screen RAM read port plus pixel stream bundle
interface hack_screen_scanner_if;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        pix;
  logic        pix_valid;
  logic        pix_ready;
  logic        sof;
  logic        eol;
  logic        eof;

  // Scanner side: drives the RAM address and the pixel stream
  modport master (
    output scr_addr,
    input  scr_data,
    output pix,
    output pix_valid,
    input  pix_ready,
    output sof,
    output eol,
    output eof
  );

  // Environment side: screen RAM read port and pixel sink
  modport slave (
    input  scr_addr,
    output scr_data,
    input  pix,
    input  pix_valid,
    output pix_ready,
    input  sof,
    input  eol,
    input  eof
  );
endinterface

// File: rtl/hack_screen_scanner.sv
// rtl/hack_screen_scanner.sv - raster scan of Hack screen RAM into an LSB-first pixel stream
module hack_screen_scanner #(
  parameter int ROW_WORDS = 32,
  parameter int ROWS      = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic                         busy,
  hack_screen_scanner_if.master        scr
);

  localparam logic [12:0] LAST_WORD = 13'(ROWS * ROW_WORDS - 1);
  // ROW_WORDS is a power of two, so the column of a word is a simple mask
  localparam logic [12:0] COL_MASK  = 13'(ROW_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t      state, state_d;
  logic [12:0] word_idx, word_idx_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [15:0] shreg, shreg_d;

  logic valid;
  logic fire;
  logic last_bit;
  logic last_word;
  logic row_end;

  assign valid     = (state == SHIFT);
  assign fire      = valid & scr.pix_ready;
  assign last_bit  = (bit_cnt == 4'd15);
  assign last_word = (word_idx == LAST_WORD);
  assign row_end   = ((word_idx & COL_MASK) == COL_MASK);

  // State and datapath registers, cleared immediately on rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_idx <= 13'd0;
      bit_cnt  <= 4'd0;
      shreg    <= 16'd0;
    end else begin
      state    <= state_d;
      word_idx <= word_idx_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
    end
  end

  // Next-state logic: fetch one word, shift it out, advance or wrap at frame end
  always_comb begin
    state_d    = state;
    word_idx_d = word_idx;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    case (state)
      IDLE: begin
        word_idx_d = 13'd0;
        if (en) state_d = FETCH;
      end
      FETCH: begin
        shreg_d   = scr.scr_data;
        bit_cnt_d = 4'd0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (fire) begin
          shreg_d   = shreg >> 1;
          bit_cnt_d = bit_cnt + 4'd1;
          if (last_bit) begin
            if (!last_word) begin
              word_idx_d = word_idx + 13'd1;
              state_d    = FETCH;
            end else begin
              // en is only consulted here, so a frame always runs to eof
              word_idx_d = 13'd0;
              state_d    = en ? FETCH : IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the registers and qualified by pix_valid
  always_comb begin
    scr.scr_addr  = word_idx;
    scr.pix_valid = valid;
    scr.pix       = valid & shreg[0];
    scr.sof       = valid & (word_idx == 13'd0) & (bit_cnt == 4'd0);
    scr.eol       = valid & row_end & last_bit;
    scr.eof       = valid & row_end & last_bit & last_word;
    busy          = (state != IDLE);
  end

endmodule
